// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative 8x8 unsigned/signed multiply and 16/8 restoring
//               divide with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    output logic [15:0] result,
    output logic [7:0]  remainder,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_OP_MUL  = 2'b00;
    localparam logic [1:0] c_OP_MULS = 2'b01;
    localparam logic [1:0] c_OP_DIV  = 2'b10;
    localparam logic [1:0] c_OP_RSVD = 2'b11;

    logic [1:0]  r_state;
    logic [1:0]  r_op;
    logic [7:0]  r_b;
    logic [3:0]  r_cnt;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [7:0]  r_mplier;
    logic        r_neg;
    logic [7:0]  r_rem;
    logic [15:0] r_quo;

    logic [7:0]  w_mag_a;
    logic [7:0]  w_mag_b;
    logic [15:0] w_mul_sum;
    logic [15:0] w_mul_res;
    logic [8:0]  w_trial;
    logic [8:0]  w_diff;
    logic        w_ge;
    logic [7:0]  w_rem_next;
    logic [15:0] w_quo_next;
    logic        w_trivial;
    logic        w_unused;

    assign w_unused = ^operand_b[15:8];

    // Signed multiply runs on magnitudes; -128 maps to 8'h80 read as unsigned 128.
    assign w_mag_a = (op == c_OP_MULS && operand_a[7]) ? 8'd0 - operand_a[7:0] : operand_a[7:0];
    assign w_mag_b = (op == c_OP_MULS && operand_b[7]) ? 8'd0 - operand_b[7:0] : operand_b[7:0];

    assign w_mul_sum = r_acc + (r_mplier[0] ? r_mcand : 16'd0);
    assign w_mul_res = (r_op == c_OP_MULS && r_neg) ? 16'd0 - w_mul_sum : w_mul_sum;

    // Partial remainder stays below the divisor, so trial - divisor never exceeds 8 bits
    // and bit 8 of the difference alone tells whether the subtraction fits.
    assign w_trial    = {r_rem, r_quo[15]};
    assign w_diff     = w_trial - {1'b0, r_b};
    assign w_ge       = ~w_diff[8];
    assign w_rem_next = w_ge ? w_diff[7:0] : w_trial[7:0];
    assign w_quo_next = {r_quo[14:0], w_ge};

    assign w_trivial = (r_op == c_OP_RSVD) || (r_op == c_OP_DIV && r_b == 8'd0);

    assign busy = (r_state != c_IDLE);
    assign done = (r_state == c_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_op      <= c_OP_MUL;
            r_b       <= 8'd0;
            r_cnt     <= 4'd0;
            r_acc     <= 16'd0;
            r_mcand   <= 16'd0;
            r_mplier  <= 8'd0;
            r_neg     <= 1'b0;
            r_rem     <= 8'd0;
            r_quo     <= 16'd0;
            result    <= 16'd0;
            remainder <= 8'd0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state  <= c_RUN;
                        r_op     <= op;
                        r_b      <= operand_b[7:0];
                        r_cnt    <= 4'd0;
                        r_acc    <= 16'd0;
                        r_mcand  <= {8'd0, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_neg    <= (op == c_OP_MULS) && (operand_a[7] ^ operand_b[7]);
                        r_rem    <= 8'd0;
                        r_quo    <= operand_a;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RUN: begin
                    if (w_trivial) begin
                        r_state   <= c_DONE;
                        result    <= (r_op == c_OP_RSVD) ? 16'd0 : 16'hFFFF;
                        remainder <= (r_op == c_OP_RSVD) ? 8'd0 : r_quo[7:0];
                        err       <= 1'b1;
                    end else if (r_op == c_OP_DIV) begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_state   <= c_DONE;
                            result    <= w_quo_next;
                            remainder <= w_rem_next;
                            err       <= 1'b0;
                        end
                    end else begin
                        r_acc    <= w_mul_sum;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            r_state   <= c_DONE;
                            result    <= w_mul_res;
                            remainder <= 8'd0;
                            err       <= 1'b0;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Scoreboard bench for mul_div_unit; arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [15:0] result;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [15:0] res;
        logic [7:0]  rem;
        logic        err;
        int          n;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;
    logic r_prev_done = 1'b0;

    mul_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        exp_t               e;
        logic signed [7:0]  sa;
        logic signed [7:0]  sbv;
        logic signed [15:0] sp;
        logic [15:0]        div16;
        logic [15:0]        rem16;
        e.res = 16'd0; e.rem = 8'd0; e.err = 1'b0; e.n = 8; e.acc = 0;
        div16 = {8'd0, b[7:0]};
        case (o)
            2'b00: e.res = {8'd0, a[7:0]} * {8'd0, b[7:0]};
            2'b01: begin
                sa = a[7:0]; sbv = b[7:0];
                sp = sa * sbv;
                e.res = sp;
            end
            2'b10: begin
                if (div16 == 16'd0) begin
                    e.res = 16'hFFFF; e.rem = a[7:0]; e.err = 1'b1; e.n = 1;
                end else begin
                    e.res = a / div16;
                    rem16 = a % div16;
                    e.rem = rem16[7:0];
                    e.n   = 16;
                end
            end
            default: begin
                e.err = 1'b1; e.n = 1;
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            check("done_pulse", {31'd0, r_prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result",    {16'd0, result},    {16'd0, e.res});
                check("remainder", {24'd0, remainder}, {24'd0, e.rem});
                check("err",       {31'd0, err},       {31'd0, e.err});
                check("latency",   cyc - e.acc,        e.n);
            end
        end
        r_prev_done = done;
    end

    // Waits until the unit can accept (IDLE or DONE), then drives one start cycle.
    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, output int acc);
        exp_t e;
        int   w = 0;
        @(negedge clk);
        while (busy && !done && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check("ready_timeout", 32'd1, 32'd0);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        operand_a = 16'($urandom);
        operand_b = 16'($urandom);
        op = 2'($urandom);
        acc = cyc;
        e = model(o, a, b);
        e.acc = acc;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while (busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        int acc;
        do_op(o, a, b, acc);
        wait_idle();
    endtask

    initial begin
        int acc1;
        int acc2;
        rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = 16'd0; operand_b = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_busy",   {31'd0, busy},      32'd0);
        check("rst_done",   {31'd0, done},      32'd0);
        check("rst_result", {16'd0, result},    32'd0);
        check("rst_rem",    {24'd0, remainder}, 32'd0);
        check("rst_err",    {31'd0, err},       32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        run_op(2'b00, 16'h00FF, 16'h00FF);
        run_op(2'b01, 16'hAAFE, 16'hAA03);
        run_op(2'b01, 16'h0080, 16'h0080);
        run_op(2'b10, 16'h1234, 16'h0010);
        run_op(2'b10, 16'hFFFF, 16'h00FF);
        run_op(2'b10, 16'hABCD, 16'h0000);
        run_op(2'b00, 16'h0003, 16'h0004);
        run_op(2'b11, 16'h5555, 16'h0033);
        run_op(2'b01, 16'h007F, 16'h0081);

        // start pulsed while RUN must be ignored
        do_op(2'b00, 16'h0005, 16'h0007, acc1);
        @(negedge clk); @(negedge clk);
        start = 1'b1; op = 2'b10; operand_a = 16'h9999; operand_b = 16'h0003;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();

        // back-to-back: second start lands in DONE
        do_op(2'b00, 16'h0011, 16'h0022, acc1);
        do_op(2'b01, 16'h00F0, 16'h0011, acc2);
        check("b2b_gap", acc2 - acc1, 32'd9);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = (i == 3) ? 16'h0000 : 16'($urandom);
            do_op(2'($urandom), ra, rb, acc1);
        end
        wait_idle();

        // asynchronous reset mid-DIV
        run_op(2'b00, 16'h0009, 16'h0009);
        do_op(2'b10, 16'h1234, 16'h0010, acc1);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy",   {31'd0, busy},      32'd0);
        check("arst_done",   {31'd0, done},      32'd0);
        check("arst_result", {16'd0, result},    32'd0);
        check("arst_rem",    {24'd0, remainder}, 32'd0);
        check("arst_err",    {31'd0, err},       32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        run_op(2'b00, 16'h000C, 16'h000B);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
